// File: rtl/sram_pkg.sv
// Shared types and helpers for the synchronous SRAM controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: controller state enum, default geometry, byte parity helper.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;

    // Even parity: the stored bit makes the total count of ones (data + parity) even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sram_sync_ctrl_if.sv
// Request/response bundle between a host and sram_sync_ctrl.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on requests, rsp_valid/rsp_ready on read responses.
// Ports: master = host side, slave = controller side. rsp_perr/inj_perr exist only
// when SRAM_PARITY_EN is defined.
interface sram_sync_ctrl_if
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = 8
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BYTES-1:0]      req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  init_done;
    logic                  err_oob;
`ifdef SRAM_PARITY_EN
    logic                  rsp_perr;
    logic                  inj_perr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, inj_perr,
        input  req_ready, rsp_valid, rsp_rdata, init_done, err_oob, rsp_perr
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, inj_perr,
        output req_ready, rsp_valid, rsp_rdata, init_done, err_oob, rsp_perr
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, init_done, err_oob
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, init_done, err_oob
    );
`endif

endinterface

// File: rtl/sram_clear_seq.sv
// Walks every word address once after reset so the array can be filled with the init value.
// Latency: one address per cycle, RAM_DEPTH cycles total; clr_done rises with the last write.
// Backpressure: none; runs unconditionally until done, restarts on reset.
// Ports: clk, reset (sync, active-high) in; clr_we, clr_addr, clr_done out.
module sram_clear_seq #(
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_done
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (!done_q) begin
            if (cnt_q == LAST_ADDR) begin
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign clr_we   = !done_q;
    assign clr_addr = cnt_q;
    assign clr_done = done_q;

endmodule

// File: rtl/sram_sync_ctrl.sv
// Single-port synchronous SRAM with valid/ready requests, registered read response and clear-on-reset.
// Latency: read data one cycle after acceptance; writes complete at the accepting edge.
// Backpressure: one-entry response register; requests stall while a response is held by !rsp_ready.
// Ports: clk, reset (sync, active-high), bus (sram_sync_ctrl_if.slave).
// Optional: define SRAM_PARITY_EN to store a per-byte even-parity bit and expose rsp_perr/inj_perr.
module sram_sync_ctrl
    import sram_pkg::*;
#(
    parameter int                  DATA_WIDTH = 16,
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  RAM_DEPTH  = 256,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    sram_sync_ctrl_if.slave  bus
);
    localparam int BYTES = DATA_WIDTH / 8;
`ifdef SRAM_PARITY_EN
    localparam int STORE_W = DATA_WIDTH + BYTES;   // parity bits sit above the data bits
`else
    localparam int STORE_W = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    // One extra bit so RAM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [STORE_W-1:0] mem_q [RAM_DEPTH];

    sram_state_e state_q, state_d;

    logic                  clr_we, clr_done;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic                  req_ready, accept, in_range;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BYTES-1:0]      wr_be;
    logic [STORE_W-1:0]    rd_word;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  rsp_valid_q, err_oob_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
`ifdef SRAM_PARITY_EN
    logic                  wr_inj;
    logic                  rd_perr;
    logic                  rsp_perr_q;
`endif

    sram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_done (clr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave CLEAR on the same edge that writes the last word, in step with clr_done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_we && clr_addr == LAST_ADDR) state_d = READY;
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    assign req_ready = (state_q == READY) && (!rsp_valid_q || bus.rsp_ready);
    assign accept    = bus.req_valid && req_ready;
    assign in_range  = {1'b0, bus.req_addr} < DEPTH_EXT;

    // Single write port: the clear sequencer owns it in CLEAR, the host in READY.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_addr;
        wr_data = INIT_VALUE;
        wr_be   = '1;
        if (state_q == CLEAR) begin
            wr_en = clr_we;
        end else if (accept && bus.req_we && in_range) begin
            wr_en   = 1'b1;
            wr_addr = bus.req_addr;
            wr_data = bus.req_wdata;
            wr_be   = bus.req_be;
        end
    end

`ifdef SRAM_PARITY_EN
    assign wr_inj = bus.inj_perr;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
`ifdef SRAM_PARITY_EN
                    mem_q[wr_addr][DATA_WIDTH + i] <= byte_parity(wr_data[8*i +: 8]) ^ wr_inj;
`endif
                end
            end
        end
    end

    assign rd_word = mem_q[bus.req_addr];
    assign rd_data = in_range ? rd_word[DATA_WIDTH-1:0] : '0;

`ifdef SRAM_PARITY_EN
    always_comb begin
        rd_perr = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            rd_perr = rd_perr | (byte_parity(rd_word[8*i +: 8]) ^ rd_word[DATA_WIDTH + i]);
        end
        rd_perr = rd_perr & in_range;
    end
`endif

    // Response register: loads on an accepted read, otherwise drains on rsp_ready and holds when stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_oob_q   <= 1'b0;
`ifdef SRAM_PARITY_EN
            rsp_perr_q  <= 1'b0;
`endif
        end else begin
            err_oob_q <= accept && !in_range;
            if (accept && !bus.req_we) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rd_data;
`ifdef SRAM_PARITY_EN
                rsp_perr_q  <= rd_perr;
`endif
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.init_done = clr_done;
    assign bus.err_oob   = err_oob_q;
`ifdef SRAM_PARITY_EN
    assign bus.rsp_perr  = rsp_perr_q;
`endif

endmodule

// File: tb/tb_sram_sync_ctrl.sv
// Directed bench for sram_sync_ctrl: a 256-word instance and a 200-word instance share stimulus.
// Latency: n/a.
// Backpressure: exercises response stall via rsp_ready.
module tb_sram_sync_ctrl;
    import sram_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                sel;      // 0 = 256-word DUT, 1 = 200-word DUT
    logic                vld;
    logic                we;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       wdata;
    logic [BE_WIDTH-1:0] be;
    logic                rrdy;
    logic                inj;

    int checks   = 0;
    int failures = 0;

    sram_sync_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    sram_sync_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    sram_sync_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (256),
        .INIT_VALUE (16'h0000)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    sram_sync_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (200),
        .INIT_VALUE (16'h0000)
    ) u_dut_200 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    assign bus_a.req_valid = vld & ~sel;
    assign bus_b.req_valid = vld & sel;
    assign bus_a.req_we    = we;
    assign bus_b.req_we    = we;
    assign bus_a.req_addr  = addr;
    assign bus_b.req_addr  = addr;
    assign bus_a.req_wdata = wdata;
    assign bus_b.req_wdata = wdata;
    assign bus_a.req_be    = be;
    assign bus_b.req_be    = be;
    assign bus_a.rsp_ready = rrdy;
    assign bus_b.rsp_ready = rrdy;
`ifdef SRAM_PARITY_EN
    assign bus_a.inj_perr  = inj;
    assign bus_b.inj_perr  = inj;
`endif

    wire          o_rdy   = sel ? bus_b.req_ready : bus_a.req_ready;
    wire          o_vld   = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    wire [DW-1:0] o_rdata = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    wire          o_oob   = sel ? bus_b.err_oob   : bus_a.err_oob;
    wire          o_done  = sel ? bus_b.init_done : bus_a.init_done;
`ifdef SRAM_PARITY_EN
    wire          o_perr  = sel ? bus_b.rsp_perr  : bus_a.rsp_perr;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted (bounded); returns #1 after the accepting edge.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BE_WIDTH-1:0] b);
        int n;
        we = w; addr = a; wdata = d; be = b; vld = 1'b1;
        #1;
        n = 0;
        while (!o_rdy && n < 50) begin
            cyc();
            n++;
        end
        if (!o_rdy) chk("req_ready_timeout", {31'd0, o_rdy}, 32'd1);
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BE_WIDTH-1:0] b);
        rrdy = 1'b1;
        send(1'b1, a, d, b);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        rrdy = 1'b1;
        send(1'b0, a, '0, '0);
        chk({tag, "_vld"}, {31'd0, o_vld}, 32'd1);
        chk(tag, {16'd0, o_rdata}, {16'd0, exp});
    endtask

    // Counts edges after reset release until init_done rises (bounded).
    task automatic wait_init(output int n);
        n = 0;
        while (!o_done && n < 400) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, nb;
        bit  early;
        bit  done_seen;

        reset = 1'b1; sel = 1'b0; vld = 1'b0; we = 1'b0; addr = '0;
        wdata = '0; be = '0; rrdy = 1'b1; inj = 1'b0;

        repeat (3) cyc();
        chk("rst_rsp_valid", {31'd0, o_vld},   32'd0);
        chk("rst_rsp_rdata", {16'd0, o_rdata}, 32'd0);
        chk("rst_init_done", {31'd0, o_done},  32'd0);
        chk("rst_err_oob",   {31'd0, o_oob},   32'd0);
        chk("rst_req_ready", {31'd0, o_rdy},   32'd0);

        // Clear sequence timing for both depths, req_ready held low meanwhile.
        vld = 1'b1;
        reset = 1'b0;
        n = 0; nb = 0; early = 1'b0;
        while (!bus_a.init_done && n < 400) begin
            cyc();
            n++;
            if (!bus_a.init_done && bus_a.req_ready) early = 1'b1;
            if (bus_b.init_done && nb == 0) nb = n;
        end
        vld = 1'b0;
        chk("init_cycles_256", n, 32'd256);
        chk("init_cycles_200", nb, 32'd200);
        chk("rdy_before_init", {31'd0, early}, 32'd0);

        rd(8'h7C, 16'h0000, "rd_7c_init");

        // Byte enables.
        wr(8'h32, 16'h1234, 2'b11);
        chk("wr_in_range_oob", {31'd0, o_oob}, 32'd0);
        wr(8'h32, 16'h00AB, 2'b01);
        rd(8'h32, 16'h12AB, "rd_32_be01");
        wr(8'h32, 16'hFFFF, 2'b00);
        chk("wr_be0_oob", {31'd0, o_oob}, 32'd0);
        rd(8'h32, 16'h12AB, "rd_32_be00");
        wr(8'h32, 16'hCD00, 2'b10);
        rd(8'h32, 16'hCDAB, "rd_32_be10");

        // Back-to-back reads then stall.
        for (int i = 0; i < 4; i++) wr(AW'(8'h10 + i), DW'(16'hA010 + i), 2'b11);
        rrdy = 1'b1; we = 1'b0; vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = AW'(8'h10 + i);
            cyc();
            chk($sformatf("b2b_vld_%0d", i), {31'd0, o_vld}, 32'd1);
            chk($sformatf("b2b_rdata_%0d", i), {16'd0, o_rdata}, 32'hA010 + i);
        end
        rrdy = 1'b0; addr = 8'h11;
        #1;
        chk("stall_req_ready", {31'd0, o_rdy}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("stall_vld",   {31'd0, o_vld},   32'd1);
            chk("stall_rdata", {16'd0, o_rdata}, 32'h0000A013);
        end
        vld = 1'b0; rrdy = 1'b1;
        cyc();
        chk("drain_vld", {31'd0, o_vld}, 32'd0);

        // Out-of-range on the 200-word instance.
        sel = 1'b1;
        wr(8'hC7, 16'hBEEF, 2'b11);
        chk("d200_last_oob", {31'd0, o_oob}, 32'd0);
        rd(8'hC7, 16'hBEEF, "d200_rd_last");
        wr(8'hF2, 16'h5A5A, 2'b11);
        chk("d200_oob_wr_pulse", {31'd0, o_oob}, 32'd1);
        cyc();
        chk("d200_oob_wr_end", {31'd0, o_oob}, 32'd0);
        rd(8'hF2, 16'h0000, "d200_oob_rd");
        chk("d200_oob_rd_pulse", {31'd0, o_oob}, 32'd1);
        rd(8'hC8, 16'h0000, "d200_oob_rd_c8");
        chk("d200_oob_c8_pulse", {31'd0, o_oob}, 32'd1);
        sel = 1'b0;

        // Reset mid-READY, then again 100 cycles into the clear.
        wr(8'hF2, 16'h0078, 2'b11);
        rd(8'hF2, 16'h0078, "rd_f2_before_rst");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst_ready_clears_done", {31'd0, o_done}, 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (o_done) done_seen = 1'b1;
        end
        chk("done_low_first_100", {31'd0, done_seen}, 32'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wait_init(n);
        chk("reinit_cycles", n, 32'd256);
        rd(8'hF2, 16'h0000, "rd_f2_after_rst");

`ifdef SRAM_PARITY_EN
        inj = 1'b1;
        wr(8'h40, 16'h5555, 2'b11);
        inj = 1'b0;
        rd(8'h40, 16'h5555, "par_inj_rdata");
        chk("par_inj_perr", {31'd0, o_perr}, 32'd1);
        wr(8'h41, 16'h5555, 2'b11);
        rd(8'h41, 16'h5555, "par_ok_rdata");
        chk("par_ok_perr", {31'd0, o_perr}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_sync_ctrl.md
Name: sram_sync_ctrl

Overview:
- Synchronous single-port SRAM with a valid/ready request channel, a registered response channel and a hardware clear sequencer.
- Replaces combinational chip/write/output-enable SRAM models in the datapath. Host processors and the divider test harness access it through a clean handshake; there are no tri-state buses.
- Width, depth and initial fill value are parametrised. Per-byte write enables are supported.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width in bits.
- RAM_DEPTH, 256, number of words; must satisfy RAM_DEPTH <= 2**ADDR_WIDTH.
- INIT_VALUE, 0, value written to every word during the clear sequence.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_be  in  DATA_WIDTH/8  byte write enables; bit i covers byte i
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DATA_WIDTH  read data
- init_done  out  1  clear sequence finished; memory is usable
- err_oob  out  1  one-cycle pulse when an accepted request addresses a word >= RAM_DEPTH

Behaviour:
- Reset, sampled at the clock edge:
  - FSM enters CLEAR and the clear counter goes to 0.
  - rsp_valid=0, rsp_rdata=0, init_done=0, err_oob=0, req_ready=0.
  - Any pending response is discarded.
- FSM states are CLEAR and READY.
- CLEAR:
  - Each cycle writes INIT_VALUE to mem[cnt], then increments cnt.
  - When cnt==RAM_DEPTH-1 has been written, the FSM goes to READY on the next edge and init_done becomes 1. The clear takes exactly RAM_DEPTH cycles after reset deasserts.
  - req_ready is held at 0 throughout.
- Reset asserted during CLEAR or READY restarts the clear from address 0.
- READY:
  - req_ready = !rsp_valid || rsp_ready. This is a one-entry response register, so a new read is not accepted while an unconsumed response is stalled.
- Accepted write:
  - For each i, if req_be[i] then mem[addr] byte i <= wdata byte i at the same edge. Bytes with req_be[i]=0 are unchanged.
  - A write produces no response. Writes may be accepted while rsp_valid=1 only if rsp_ready=1, per the req_ready rule.
- Accepted read:
  - rsp_rdata <= mem[addr] and rsp_valid <= 1 on the accepting edge, giving 1-cycle latency.
  - rsp_rdata holds stable while rsp_valid && !rsp_ready.
  - rsp_valid clears on the edge where rsp_ready=1 unless a new read is accepted on that same edge. Back-to-back reads therefore sustain one per cycle when rsp_ready=1.
- Ordering: a read following a write to the same address returns the written data, because one operation occurs per cycle and the write completes at the edge.
- Out-of-range address (addr >= RAM_DEPTH):
  - A write is dropped.
  - A read returns 0 with rsp_valid=1.
  - err_oob pulses for one cycle in both cases.
- An all-zero req_be on a write is legal: nothing changes and no error is raised.

Optional Feature:
- Macro SRAM_PARITY_EN.
- When defined:
  - Each byte stores an extra even-parity bit. Parity is written alongside the data on writes and during CLEAR.
  - Reads recompute the parity and drive the added output port rsp_perr (width 1, valid with rsp_valid). rsp_perr=1 if any byte mismatches.
  - A debug input inj_perr (width 1) inverts the stored parity of the bytes written in that cycle.
- When undefined: rsp_perr and inj_perr do not exist, and the storage is DATA_WIDTH bits per word.

Decomposition:
- Package sram_pkg holds:
  - typedef enum sram_state_e {CLEAR, READY}
  - function byte_parity
  - localparam BE_WIDTH = DATA_WIDTH/8
- Sub-module sram_clear_seq: the clear counter and done flag.
  - Inputs: clk, reset.
  - Outputs: clr_we, clr_addr, clr_done.
  - The top-level muxes its write port onto the memory array.

Test Plan:
- Reset release → init_done rises exactly 256 cycles later; a read of address 0x7C returns 0x0000; req_ready stays 0 before init_done.
- Write 0x1234 to 0x32 with be=2'b11, then write 0xAB to 0x32 with be=2'b01 → read of 0x32 returns 0x12AB one cycle after acceptance.
- Back-to-back reads of 0x10..0x13 with rsp_ready=1 → four consecutive rsp_valid cycles with the correct data. Then hold rsp_ready=0 → req_ready=0 and rsp_rdata stays stable.
- Build with RAM_DEPTH=200 and read 0xF2 → rsp_rdata=0 and an err_oob pulse; a write to 0xF2 is dropped with err_oob.
- Assert reset at cycle 100 of the clear after writing nothing, and mid-READY after writing 0x0078 to 0xF2 → clear restarts, init_done=0 for 256 cycles, and a read of 0xF2 afterwards returns INIT_VALUE.
- With SRAM_PARITY_EN defined, write 0x5555 with inj_perr=1 → a read of that address returns rsp_perr=1; a normal write then read → rsp_perr=0.
